// File: rtl/spi_flash_io_phy.sv
// spi_flash_io_phy: SPI/dual/quad flash pad PHY with divided sck, chip-select sequencing and lane (de)serialisation.
module spi_flash_io_phy #(
  parameter int DATA_W       = 8,
  parameter int DIV_W        = 8,
  parameter int QUAD_EN      = 1,
  parameter int CS_SETUP_CYC = 2,
  parameter int CS_HOLD_CYC  = 2,
  parameter int CS_IDLE_MIN  = 4
) (
  input  logic              i_clk_spi_flash,
  input  logic              i_rst_n,
  input  logic [DIV_W-1:0]  i_clk_div,
  input  logic              i_cs_req,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic [1:0]        i_lane_mode,
  input  logic              i_dir,
  input  logic              i_sample_dly,
  output logic              o_rx_valid,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_busy,
  output logic              o_csn,
  output logic              o_sck,
  output logic [3:0]        o_io_out,
  output logic [3:0]        o_io_oen,
  input  logic [3:0]        i_io_in
);
  localparam logic [2:0] S_IDLE = 3'd0, S_SETUP = 3'd1, S_ACTIVE = 3'd2, S_SHIFT = 3'd3, S_HOLD = 3'd4;
  localparam int BW = $clog2(DATA_W + 1);
  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d, hcnt_q, hcnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d, last_beat;
  logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, rx_data_q, rx_data_d, rx_sh, rx_nx;
  logic [1:0] mode_q, mode_d;
  logic sck_q, sck_d, dir_q, dir_d, dly_q, dly_d, pend_q, pend_d, rx_valid_q, rx_valid_d;
  logic hz, rise, fall, samp;
  // mode_q: 0 single, 1 dual, 2 quad (already resolved against QUAD_EN)
  assign hz        = hcnt_q == '0;
  assign rise      = state_q == S_SHIFT && hz && !sck_q;
  assign fall      = state_q == S_SHIFT && hz && sck_q;
  assign samp      = dir_q && (dly_q ? pend_q : rise);
  assign last_beat = mode_q == 2'd2 ? BW'(DATA_W/4 - 1) : mode_q == 2'd1 ? BW'(DATA_W/2 - 1) : BW'(DATA_W - 1);
  assign rx_sh     = mode_q == 2'd2 ? (rx_q << 4) | DATA_W'(i_io_in) :
                     mode_q == 2'd1 ? (rx_q << 2) | DATA_W'(i_io_in[1:0]) : (rx_q << 1) | DATA_W'(i_io_in[1]);
  assign rx_nx     = samp ? rx_sh : rx_q;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    hcnt_d     = hcnt_q;
    sck_d      = sck_q;
    bcnt_d     = bcnt_q;
    tx_d       = tx_q;
    rx_d       = rx_nx;
    rx_data_d  = rx_data_q;
    mode_d     = mode_q;
    dir_d      = dir_q;
    dly_d      = dly_q;
    pend_d     = rise;
    rx_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = cnt_q < 8'(CS_IDLE_MIN - 1) ? cnt_q + 8'd1 : cnt_q;
        if (i_cs_req && cnt_q >= 8'(CS_IDLE_MIN - 1)) begin
          state_d = S_SETUP;
          cnt_d   = '0;
        end
      end
      S_SETUP: begin
        cnt_d   = cnt_q + 8'd1;
        state_d = cnt_q == 8'(CS_SETUP_CYC - 1) ? S_ACTIVE : S_SETUP;
      end
      S_ACTIVE: begin
        if (i_tx_valid) begin
          state_d = S_SHIFT;
          tx_d    = i_tx_data;
          mode_d  = i_lane_mode == 2'b01 ? 2'd1 : (i_lane_mode == 2'b10 && QUAD_EN != 0) ? 2'd2 : 2'd0;
          dir_d   = i_dir;
          dly_d   = i_sample_dly;
          div_d   = i_clk_div;
          hcnt_d  = i_clk_div;
          bcnt_d  = '0;
          rx_d    = '0;
        end else if (!i_cs_req) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end
      end
      S_SHIFT: begin
        hcnt_d = hz ? div_q : hcnt_q - 1'b1;
        sck_d  = hz ? !sck_q : sck_q;
        if (fall) begin
          bcnt_d = bcnt_q + 1'b1;
          tx_d   = mode_q == 2'd2 ? tx_q << 4 : mode_q == 2'd1 ? tx_q << 2 : tx_q << 1;
        end
        // the final falling edge closes the word; a delayed sample may land on this same edge
        if (fall && bcnt_q == last_beat) begin
          state_d    = S_ACTIVE;
          rx_valid_d = dir_q;
          rx_data_d  = dir_q ? rx_nx : rx_data_q;
        end
      end
      S_HOLD: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'(CS_HOLD_CYC - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk_spi_flash or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'(CS_IDLE_MIN - 1);
      div_q      <= '0;
      hcnt_q     <= '0;
      sck_q      <= 1'b0;
      bcnt_q     <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rx_data_q  <= '0;
      mode_q     <= 2'd0;
      dir_q      <= 1'b0;
      dly_q      <= 1'b0;
      pend_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      hcnt_q     <= hcnt_d;
      sck_q      <= sck_d;
      bcnt_q     <= bcnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rx_data_q  <= rx_data_d;
      mode_q     <= mode_d;
      dir_q      <= dir_d;
      dly_q      <= dly_d;
      pend_q     <= pend_d;
      rx_valid_q <= rx_valid_d;
    end
  end
  assign o_csn      = state_q == S_IDLE;
  assign o_sck      = sck_q;
  assign o_tx_ready = state_q == S_ACTIVE;
  assign o_busy     = state_q != S_IDLE;
  assign o_rx_valid = rx_valid_q;
  assign o_rx_data  = rx_data_q;
  assign o_io_out   = (state_q != S_SHIFT || dir_q) ? 4'b1100 :
                      mode_q == 2'd2 ? tx_q[DATA_W-1 -: 4] :
                      mode_q == 2'd1 ? {2'b11, tx_q[DATA_W-1 -: 2]} : {3'b110, tx_q[DATA_W-1]};
  assign o_io_oen   = state_q != S_SHIFT ? 4'b0011 :
                      mode_q == 2'd2 ? {4{dir_q}} :
                      mode_q == 2'd1 ? {2'b00, {2{dir_q}}} : {3'b001, dir_q};
endmodule

// File: tb/tb_spi_flash_io_phy.sv
// tb_spi_flash_io_phy: directed self-checking bench with a small mode-0 flash read model.
module tb_spi_flash_io_phy;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] clk_div = '0, tx_data = '0, rx_data;
  logic cs_req = 1'b0, tx_valid = 1'b0, tx_ready, dir = 1'b0, sample_dly = 1'b0;
  logic rx_valid, busy, csn, sck;
  logic [1:0] lane_mode = 2'b00;
  logic [3:0] io_out, io_oen, io_in;
  int tests = 0, fails = 0;
  logic [7:0] fl_word = '0, fsh;
  int fl_lanes = 1, fl_base = 0, nf = 0;

  spi_flash_io_phy dut (
    .i_clk_spi_flash(clk), .i_rst_n(rst_n), .i_clk_div(clk_div), .i_cs_req(cs_req),
    .i_tx_valid(tx_valid), .o_tx_ready(tx_ready), .i_tx_data(tx_data), .i_lane_mode(lane_mode),
    .i_dir(dir), .i_sample_dly(sample_dly), .o_rx_valid(rx_valid), .o_rx_data(rx_data),
    .o_busy(busy), .o_csn(csn), .o_sck(sck), .o_io_out(io_out), .o_io_oen(io_oen), .i_io_in(io_in)
  );

  always #5 clk = ~clk;

  // flash shifts its next beat out shortly after each sck falling edge
  always @(negedge sck) begin
    #1 nf++;
  end
  always_comb begin
    fsh   = fl_word << (fl_lanes * (nf - fl_base));
    io_in = fl_lanes == 4 ? fsh[7:4] : fl_lanes == 2 ? {2'b00, fsh[7:6]} : {2'b00, fsh[7], 1'b0};
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic run_word(input logic [7:0] data, input logic [1:0] mode, input logic d, input logic dly,
                          input logic [7:0] div, output int cyc, output int rises, output logic [7:0] wcap,
                          output logic [3:0] oen, output logic oen_const, output int rxv,
                          output logic rx_end, output logic rx_next, output logic [7:0] rxd);
    logic prev;
    for (int i = 0; i < 50 && !tx_ready; i++) @(negedge clk);
    tests++;
    if (tx_ready !== 1'b1) begin
      fails++;
      $display("FAIL wait_tx_ready: got %b expected 1", tx_ready);
    end
    tx_valid = 1'b1; tx_data = data; lane_mode = mode; dir = d; sample_dly = dly; clk_div = div;
    fl_base = nf;
    @(negedge clk);
    tx_valid = 1'b0;
    cyc = 0; rises = 0; rxv = 0; wcap = '0; prev = 1'b0; oen = io_oen; oen_const = 1'b1;
    while (!tx_ready && cyc < 2000) begin
      cyc++;
      if (io_oen !== oen) oen_const = 1'b0;
      if (rx_valid) rxv++;
      if (sck && !prev) begin
        rises++;
        wcap = mode == 2'b10 ? {wcap[3:0], io_out} : mode == 2'b01 ? {wcap[5:0], io_out[1:0]} : {wcap[6:0], io_out[0]};
      end
      prev = sck;
      @(negedge clk);
    end
    rx_end = rx_valid; rxd = rx_data;
    @(negedge clk);
    rx_next = rx_valid;
  endtask

  task automatic test_reset;
    @(negedge clk); @(negedge clk);
    tests++; if (csn !== 1'b1) begin fails++; $display("FAIL rst_csn: got %b expected 1", csn); end
    tests++; if (sck !== 1'b0) begin fails++; $display("FAIL rst_sck: got %b expected 0", sck); end
    tests++; if (io_out !== 4'b1100) begin fails++; $display("FAIL rst_io_out: got %b expected 1100", io_out); end
    tests++; if (io_oen !== 4'b0011) begin fails++; $display("FAIL rst_io_oen: got %b expected 0011", io_oen); end
    tests++; if ({tx_ready, rx_valid, busy} !== 3'b000) begin fails++; $display("FAIL rst_flags: got %b expected 000", {tx_ready, rx_valid, busy}); end
    tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL rst_rx_data: got %h expected 00", rx_data); end
    rst_n = 1'b1;
  endtask

  task automatic test_cs_timing;
    int n;
    @(negedge clk);
    cs_req = 1'b1;
    @(negedge clk);
    tests++; if (csn !== 1'b0) begin fails++; $display("FAIL cs_low_next: got %b expected 0", csn); end
    n = 0;
    while (!tx_ready && n < 20) begin n++; @(negedge clk); end
    tests++; if (n !== 2) begin fails++; $display("FAIL setup_cycles: got %0d expected 2", n); end
    cs_req = 1'b0;
    @(negedge clk);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL hold_busy: got %b expected 1", busy); end
    n = 0;
    while (!csn && n < 20) begin n++; @(negedge clk); end
    tests++; if (n !== 2) begin fails++; $display("FAIL hold_cycles: got %0d expected 2", n); end
    cs_req = 1'b1;
    n = 0;
    while (csn && n < 20) begin n++; @(negedge clk); end
    tests++; if (n !== 4) begin fails++; $display("FAIL idle_cycles: got %0d expected 4", n); end
  endtask

  task automatic test_single_write;
    int cyc, rises, rxv; logic [7:0] w, rxd; logic [3:0] oen; logic oc, re, rn;
    run_word(8'hA5, 2'b00, 1'b0, 1'b0, 8'd0, cyc, rises, w, oen, oc, rxv, re, rn, rxd);
    tests++; if (cyc !== 16) begin fails++; $display("FAIL sw_shift_cycles: got %0d expected 16", cyc); end
    tests++; if (rises !== 8) begin fails++; $display("FAIL sw_rises: got %0d expected 8", rises); end
    tests++; if (w !== 8'hA5) begin fails++; $display("FAIL sw_dio_bits: got %h expected a5", w); end
    tests++; if ({oen, oc} !== 5'b0010_1) begin fails++; $display("FAIL sw_oen: got %b const %b expected 0010 const 1", oen, oc); end
    tests++; if ({rxv[0], re, rn} !== 3'b000) begin fails++; $display("FAIL sw_no_rx_valid: got %b expected 000", {rxv[0], re, rn}); end
    run_word(8'h3E, 2'b11, 1'b0, 1'b0, 8'd0, cyc, rises, w, oen, oc, rxv, re, rn, rxd);
    tests++; if ({cyc, w, oen} !== {32'd16, 8'h3E, 4'b0010}) begin fails++; $display("FAIL mode11_single: got cyc %0d data %h oen %b expected 16 3e 0010", cyc, w, oen); end
  endtask

  task automatic test_dual_write;
    int cyc, rises, rxv; logic [7:0] w, rxd; logic [3:0] oen; logic oc, re, rn;
    run_word(8'h6C, 2'b01, 1'b0, 1'b0, 8'd1, cyc, rises, w, oen, oc, rxv, re, rn, rxd);
    tests++; if (cyc !== 16) begin fails++; $display("FAIL dw_shift_cycles: got %0d expected 16", cyc); end
    tests++; if (w !== 8'h6C) begin fails++; $display("FAIL dw_data: got %h expected 6c", w); end
    tests++; if (oen !== 4'b0000) begin fails++; $display("FAIL dw_oen: got %b expected 0000", oen); end
  endtask

  task automatic test_quad_read;
    int cyc, rises, rxv; logic [7:0] w, rxd; logic [3:0] oen; logic oc, re, rn;
    fl_word = 8'h3C; fl_lanes = 4;
    run_word(8'hFF, 2'b10, 1'b1, 1'b0, 8'd1, cyc, rises, w, oen, oc, rxv, re, rn, rxd);
    tests++; if (cyc !== 8) begin fails++; $display("FAIL qr_shift_cycles: got %0d expected 8", cyc); end
    tests++; if ({oen, oc} !== 5'b1111_1) begin fails++; $display("FAIL qr_oen: got %b const %b expected 1111 const 1", oen, oc); end
    tests++; if (rxd !== 8'h3C) begin fails++; $display("FAIL qr_rx_data: got %h expected 3c", rxd); end
    tests++; if ({rxv[0], re, rn} !== 3'b010) begin fails++; $display("FAIL qr_rx_pulse: got %b expected 010", {rxv[0], re, rn}); end
  endtask

  task automatic test_dual_read_dly;
    int cyc, rises, rxv; logic [7:0] w, rxd; logic [3:0] oen; logic oc, re, rn;
    fl_word = 8'hB4; fl_lanes = 2;
    run_word(8'h00, 2'b01, 1'b1, 1'b1, 8'd2, cyc, rises, w, oen, oc, rxv, re, rn, rxd);
    tests++; if (cyc !== 24) begin fails++; $display("FAIL dr_shift_cycles: got %0d expected 24", cyc); end
    tests++; if (oen !== 4'b0011) begin fails++; $display("FAIL dr_oen: got %b expected 0011", oen); end
    tests++; if ({rxd, re, rn} !== {8'hB4, 2'b10}) begin fails++; $display("FAIL dr_rx: got %h pulse %b%b expected b4 pulse 10", rxd, re, rn); end
    fl_word = 8'h96; fl_lanes = 1;
    run_word(8'h00, 2'b00, 1'b1, 1'b1, 8'd0, cyc, rises, w, oen, oc, rxv, re, rn, rxd);
    tests++; if ({rxd, oen} !== {8'h96, 4'b0011}) begin fails++; $display("FAIL sr_dly_div0: got %h oen %b expected 96 oen 0011", rxd, oen); end
  endtask

  task automatic test_cs_drop_in_shift;
    int cyc, n; logic [7:0] w; logic prev;
    for (int i = 0; i < 50 && !tx_ready; i++) @(negedge clk);
    tx_valid = 1'b1; tx_data = 8'h5A; lane_mode = 2'b00; dir = 1'b0; sample_dly = 1'b0; clk_div = 8'd0;
    @(negedge clk);
    cyc = 0; w = '0; prev = 1'b0;
    while (!tx_ready && cyc < 100) begin
      if (cyc == 3) cs_req = 1'b0;
      if (sck && !prev) w = {w[6:0], io_out[0]};
      prev = sck;
      cyc++;
      @(negedge clk);
    end
    tests++; if ({cyc, w} !== {32'd16, 8'h5A}) begin fails++; $display("FAIL drop_word: got cyc %0d data %h expected 16 5a", cyc, w); end
    tests++; if (csn !== 1'b0) begin fails++; $display("FAIL drop_active_csn: got %b expected 0", csn); end
    @(negedge clk);
    tx_valid = 1'b0;
    tests++; if ({tx_ready, csn} !== 2'b00) begin fails++; $display("FAIL accept_wins: got ready/csn %b expected 00", {tx_ready, csn}); end
    n = 0;
    while (!csn && n < 200) begin n++; @(negedge clk); end
    tests++; if (n !== 19) begin fails++; $display("FAIL drop_to_idle: got %0d expected 19", n); end
  endtask

  task automatic test_reset_mid_shift;
    int rxv;
    cs_req = 1'b1;
    for (int i = 0; i < 50 && !tx_ready; i++) @(negedge clk);
    fl_word = 8'h5A; fl_lanes = 4; fl_base = nf;
    tx_valid = 1'b1; lane_mode = 2'b10; dir = 1'b1; sample_dly = 1'b0; clk_div = 8'd3;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (5) @(negedge clk);
    tests++; if ({sck, busy} !== 2'b11) begin fails++; $display("FAIL pre_reset_sck: got %b expected 11", {sck, busy}); end
    rst_n = 1'b0;
    #1;
    tests++; if ({csn, sck, tx_ready, busy, rx_valid} !== 5'b10000) begin fails++; $display("FAIL midrst_ctrl: got %b expected 10000", {csn, sck, tx_ready, busy, rx_valid}); end
    tests++; if ({io_out, io_oen} !== 8'b1100_0011) begin fails++; $display("FAIL midrst_io: got %b expected 11000011", {io_out, io_oen}); end
    rxv = 0;
    repeat (2) begin @(negedge clk); if (rx_valid) rxv++; end
    rst_n = 1'b1; cs_req = 1'b0;
    repeat (20) begin @(negedge clk); if (rx_valid) rxv++; end
    tests++; if ({rxv, rx_data} !== {32'd0, 8'h00}) begin fails++; $display("FAIL midrst_no_rx: got pulses %0d data %h expected 0 00", rxv, rx_data); end
  endtask

  initial begin
    test_reset;
    test_cs_timing;
    test_single_write;
    test_dual_write;
    test_quad_read;
    test_dual_read_dly;
    test_cs_drop_in_shift;
    test_reset_mid_shift;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spi_flash_io_phy.md
Name: spi_flash_io_phy

Overview:
- Parametrised SPI/dual/quad flash pad PHY. It sits between the SPI flash controller core and the DIO/DO/WPn/HOLDn pads.
- Generates a divided, glitch-free SPI clock and sequences chip-select setup, hold and idle timing.
- Serialises and deserialises one DATA_W-bit word per tx handshake over 1, 2 or 4 lanes, MSB first.
- Drives per-lane output enables and samples read data with an optional one-cycle sample delay.

Parameters:
- DATA_W, 8: word width; must be a multiple of 4.
- DIV_W, 8: width of the clock-divider input.
- QUAD_EN, 1: when 0, lane mode 2'b10 is treated as single.
- CS_SETUP_CYC, 2: system cycles from csn low to first tx_ready.
- CS_HOLD_CYC, 2: system cycles csn stays low after the last word.
- CS_IDLE_MIN, 4: minimum system cycles csn stays high between transactions.

Ports:
- i_clk_spi_flash  in  1  system clock; all logic on its rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_clk_div  in  DIV_W  SPI half-period H = i_clk_div+1 cycles; latched at word accept.
- i_cs_req  in  1  request chip select; held for the whole transaction.
- i_tx_valid  in  1  word request.
- o_tx_ready  out  1  PHY can accept a word.
- i_tx_data  in  DATA_W  write data (ignored for reads).
- i_lane_mode  in  2  00 single, 01 dual, 10 quad, 11 single; latched at accept.
- i_dir  in  1  0 write (drive), 1 read (tristate and sample); latched at accept.
- i_sample_dly  in  1  1: sample one cycle after the sck rising edge; latched at accept.
- o_rx_valid  out  1  one-cycle pulse, read word complete.
- o_rx_data  out  DATA_W  read word; held until the next read completes.
- o_busy  out  1  high in any state other than IDLE.
- o_csn  out  1  flash chip select, active low.
- o_sck  out  1  SPI clock, mode 0.
- o_io_out  out  4  pad data [3]=HOLDn [2]=WPn [1]=DO [0]=DIO.
- o_io_oen  out  4  per-pad output enable; 0 = drive, 1 = tristate.
- i_io_in  in  4  pad input values.

Behaviour:
- Reset values (asynchronous, immediate, also mid-operation): state IDLE, o_csn=1, o_sck=0, o_io_out=4'b1100, o_io_oen=4'b0011, o_tx_ready=0, o_rx_valid=0, o_rx_data=0, o_busy=0. The idle counter is preset so that SETUP may start immediately after reset.
- State machine: IDLE -> SETUP -> ACTIVE <-> SHIFT, ACTIVE -> HOLD -> IDLE.
- IDLE:
  - csn=1.
  - Goes to SETUP when i_cs_req=1 and csn has been high for at least CS_IDLE_MIN cycles.
- SETUP:
  - csn=0 on the first SETUP cycle.
  - Lasts CS_SETUP_CYC cycles, then goes to ACTIVE.
- ACTIVE:
  - csn=0, sck=0, o_tx_ready=1.
  - tx_valid & tx_ready latches data, mode, dir, H and sample_dly, then enters SHIFT next cycle.
  - i_cs_req=0 with no accept goes to HOLD. If both occur in the same cycle, the accept wins.
- SHIFT:
  - tx_ready=0.
  - beats = DATA_W/bits, where bits = 1/2/4 per the latched mode.
  - Half-period counter loads H-1 on entry, decrements every cycle, and toggles sck and reloads at 0.
  - SHIFT lasts exactly beats*2H cycles, then returns to ACTIVE.
  - Write beat data is on o_io_out from the first SHIFT cycle and changes only with each sck falling edge.
  - Read sampling occurs on the cycle sck rises, or one cycle later when sample_dly=1.
  - Dropping i_cs_req during SHIFT has no effect; the word completes, then ACTIVE -> HOLD.
- HOLD:
  - csn=0, sck=0, lasts CS_HOLD_CYC cycles.
  - Then IDLE with csn=1; the idle counter restarts.
- Lane mapping (MSB first):
  - Single: write drives DIO; read samples DO.
  - Dual: io[1:0], io1 = more significant bit.
  - Quad: io[3:0], io3 = most significant bit.
- Output enables:
  - Single/dual: io2/io3 driven 1; used lanes driven for writes (oen=0) and tristated for reads (oen=1); unused io0/io1 lanes tristated.
  - Quad write: o_io_oen=4'b0000. Quad read: o_io_oen=4'b1111.
  - ACTIVE/SETUP/HOLD: same enables as IDLE.
- Read completion:
  - o_rx_data is updated and o_rx_valid pulses in the first ACTIVE cycle after SHIFT.
  - No pulse is generated for writes.
- sck never shows a pulse shorter than H cycles. Changes to i_clk_div during SHIFT are ignored.

Test Plan:
- Reset -> csn=1, sck=0, io_out=4'b1100, oen=4'b0011, tx_ready=0. Assert i_rst_n=0 mid-SHIFT -> same values immediately, and o_rx_valid is never asserted.
- cs_req=1 -> csn low next cycle; tx_ready rises after 2 SETUP cycles. cs_req=0 in ACTIVE -> csn stays low 2 cycles, then high. Re-request immediately -> csn stays high for 4 cycles before going low.
- Single write 0xA5, div=0 -> DIO presents 1,0,1,0,0,1,0,1 across 8 sck rising edges; SHIFT lasts 16 cycles; oen=4'b0010; no rx_valid.
- Quad read, div=1, flash drives 4'h3 then 4'hC -> SHIFT lasts 8 cycles, oen=4'b1111, rx_data=8'h3C, and rx_valid pulses once.
- Dual read 0xB4 with sample_dly=1, div=2 -> rx_data=8'hB4; each sample is taken 1 cycle after sck rises; SHIFT lasts 24 cycles.
- cs_req dropped at cycle 3 of a single-mode write -> all 8 bits are shifted, then HOLD -> csn high. A tx_valid held during SHIFT is accepted only in ACTIVE.
